// File: rtl/taxi_dma_ram_if.sv
// Segmented DMA RAM read-side interface: per-segment command and response channels.
// Each segment handshakes independently; the data fields are packed per segment.
interface taxi_dma_ram_if #(
    parameter int SEGS       = 2,
    parameter int SEG_ADDR_W = 8,
    parameter int SEG_DATA_W = 64
);
    logic [SEGS-1:0][SEG_ADDR_W-1:0] rd_cmd_addr;
    logic [SEGS-1:0]                 rd_cmd_valid;
    logic [SEGS-1:0]                 rd_cmd_ready;
    logic [SEGS-1:0][SEG_DATA_W-1:0] rd_resp_data;
    logic [SEGS-1:0]                 rd_resp_valid;
    logic [SEGS-1:0]                 rd_resp_ready;

    modport rd_mst (
        output rd_cmd_addr,
        output rd_cmd_valid,
        input  rd_cmd_ready,
        input  rd_resp_data,
        input  rd_resp_valid,
        output rd_resp_ready
    );

    modport rd_slv (
        input  rd_cmd_addr,
        input  rd_cmd_valid,
        output rd_cmd_ready,
        output rd_resp_data,
        output rd_resp_valid,
        input  rd_resp_ready
    );
endinterface

// File: rtl/taxi_dma_ram_rd_stream.sv
// Read-side stream engine for the segmented DMA RAM: issues lockstep reads across
// all segments, buffers the per-segment responses and emits them as a word stream.
module taxi_dma_ram_rd_stream #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16,
    parameter int SEGS       = 2,
    parameter int SEG_ADDR_W = 8,
    parameter int SEG_DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    taxi_dma_ram_if.rd_mst             dma_ram_rd,
    input  logic [SEG_ADDR_W-1:0]      req_addr,
    input  logic [LEN_W-1:0]           req_len,
    input  logic                       req_valid,
    output logic                       req_ready,
    output logic [SEGS*SEG_DATA_W-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state;
    logic [SEG_ADDR_W-1:0]   cmd_addr;
    logic [LEN_W-1:0]        cmd_rem;
    logic [LEN_W-1:0]        out_rem;
    logic [PTR_W:0]          credit;
    logic [SEGS-1:0]         acc;

    logic [SEG_DATA_W-1:0]   fifo_mem [SEGS][FIFO_DEPTH];
    logic [PTR_W:0]          wr_ptr [SEGS];
    logic [PTR_W:0]          rd_ptr [SEGS];

    logic [SEGS-1:0]         cmd_valid;
    logic [SEGS-1:0]         cmd_hs;
    logic [SEGS-1:0]         fifo_full;
    logic [SEGS-1:0]         fifo_empty;
    logic [SEGS-1:0]         push;
    logic                    can_issue;
    logic                    word_done;
    logic                    pop;

    // Credit counts words issued but not yet popped, so the FIFOs can never overflow.
    assign can_issue = (state == ISSUE) && (credit < DEPTH_C);
    assign word_done = can_issue && (&(acc | cmd_hs));
    assign out_valid = &(~fifo_empty);
    assign out_last  = out_valid && (out_rem == '0);
    assign pop       = out_valid && out_ready;

    assign dma_ram_rd.rd_cmd_addr   = {SEGS{cmd_addr}};
    assign dma_ram_rd.rd_cmd_valid  = cmd_valid;
    assign dma_ram_rd.rd_resp_ready = ~fifo_full;

    always_comb begin
        cmd_valid  = '0;
        cmd_hs     = '0;
        fifo_full  = '0;
        fifo_empty = '0;
        push       = '0;
        out_data   = '0;
        for (int n = 0; n < SEGS; n++) begin
            cmd_valid[n]  = can_issue && !acc[n];
            cmd_hs[n]     = cmd_valid[n] && dma_ram_rd.rd_cmd_ready[n];
            fifo_full[n]  = (wr_ptr[n] ^ rd_ptr[n]) == {1'b1, {PTR_W{1'b0}}};
            fifo_empty[n] = wr_ptr[n] == rd_ptr[n];
            push[n]       = dma_ram_rd.rd_resp_valid[n] && !fifo_full[n];
            out_data[n*SEG_DATA_W +: SEG_DATA_W] = fifo_mem[n][rd_ptr[n][PTR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            cmd_addr  <= '0;
            cmd_rem   <= '0;
            out_rem   <= '0;
            credit    <= '0;
            acc       <= '0;
        end else begin
            acc    <= word_done ? '0 : (acc | cmd_hs);
            credit <= credit + {{PTR_W{1'b0}}, word_done} - {{PTR_W{1'b0}}, pop};
            if (word_done) begin
                cmd_addr <= cmd_addr + 1'b1;
                cmd_rem  <= cmd_rem - 1'b1;
            end
            if (pop) begin
                out_rem <= out_rem - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cmd_addr  <= req_addr;
                        cmd_rem   <= req_len;
                        out_rem   <= req_len;
                        state     <= ISSUE;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (word_done && cmd_rem == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < SEGS; n++) begin
            if (push[n]) begin
                fifo_mem[n][wr_ptr[n][PTR_W-1:0]] <= dma_ram_rd.rd_resp_data[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < SEGS; n++) begin
            if (!rst_n) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
            end else begin
                if (push[n]) begin
                    wr_ptr[n] <= wr_ptr[n] + 1'b1;
                end
                if (pop) begin
                    rd_ptr[n] <= rd_ptr[n] + 1'b1;
                end
            end
        end
    end
endmodule
